ms_timer: RTL and testbench

MS_TIMER -- requirements
Module: ms_timer

---
 rtl/ms_timer.sv | 82 ++++++++
 tb/tb_ms_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_timer.sv
// Millisecond up/down counter driven by a clock-cycle prescaler.
// The count saturates at 0 and MAX_MS, with a sticky overflow flag for up-counts attempted at MAX_MS.
module ms_timer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int MAX_MS      = 2047,
  localparam int W          = $clog2(MAX_MS + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         up,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] timer_value,
  output logic         ms_tick,
  output logic         at_zero,
  output logic         at_max,
  output logic         overflow
);

  localparam int PRESC = CLK_FREQ_HZ / 1000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [W-1:0]  MAX_V      = W'(MAX_MS);

  logic [PW-1:0] presc_reg, presc_next;
  logic [W-1:0]  cnt_reg, cnt_next;
  logic          tick_reg, tick_next;
  logic          ovf_reg, ovf_next;

  always_comb begin
    presc_next = presc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    tick_next  = 1'b0;
    if (clear) begin
      presc_next = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else if (load) begin
      presc_next = '0;
      cnt_next   = (load_value > MAX_V) ? MAX_V : load_value;
      ovf_next   = 1'b0;
    end else if (enable) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        tick_next  = 1'b1;
        if (up) begin
          // Saturate at the ceiling and remember that an up-count was lost.
          if (cnt_reg == MAX_V) ovf_next = 1'b1;
          else                  cnt_next = cnt_reg + W'(1);
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - W'(1);
        end
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      cnt_reg   <= '0;
      tick_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      cnt_reg   <= cnt_next;
      tick_reg  <= tick_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign timer_value = cnt_reg;
  assign ms_tick     = tick_reg;
  assign overflow    = ovf_reg;
  assign at_zero     = (cnt_reg == '0);
  assign at_max      = (cnt_reg == MAX_V);

endmodule

// File: tb/tb_ms_timer.sv
// Scoreboard bench for ms_timer with PRESC=4, MAX_MS=7: expectations are queued as stimulus is
// applied and popped one cycle later when the DUT outputs are sampled.
module tb_ms_timer;

  localparam int CLK_FREQ_HZ = 4000;
  localparam int MAX_MS      = 7;
  localparam int PRESC       = 4;
  localparam int W           = 3;
  localparam int OW          = W + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         up = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] timer_value;
  logic         ms_tick, at_zero, at_max, overflow;

  ms_timer #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .MAX_MS(MAX_MS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .up(up), .enable(enable),
    .load(load), .load_value(load_value), .timer_value(timer_value),
    .ms_tick(ms_tick), .at_zero(at_zero), .at_max(at_max), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Observation word: {timer_value, ms_tick, at_zero, at_max, overflow}
  logic [OW-1:0] obs;
  assign obs = {timer_value, ms_tick, at_zero, at_max, overflow};

  localparam logic [OW-1:0] RESET_OBS = {3'd0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic [OW-1:0] sb[$];
  logic [OW-1:0] exp;
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_cnt = 0, m_presc = 0;
  bit m_ovf = 0;

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_ovf = 0;
  endtask

  // Predict the effect of the next rising edge, queue it, then advance to the sampling point.
  task automatic cycle();
    bit t;
    t = 0;
    if (clear) begin
      m_cnt = 0; m_presc = 0; m_ovf = 0;
    end else if (load) begin
      m_cnt = (int'(load_value) > MAX_MS) ? MAX_MS : int'(load_value);
      m_presc = 0; m_ovf = 0;
    end else if (enable) begin
      m_presc = m_presc + 1;
      if (m_presc == PRESC) begin
        m_presc = 0;
        t = 1;
        if (up) begin
          if (m_cnt == MAX_MS) m_ovf = 1; else m_cnt = m_cnt + 1;
        end else if (m_cnt > 0) begin
          m_cnt = m_cnt - 1;
        end
      end
    end
    sb.push_back({W'(m_cnt), t, (m_cnt == 0), (m_cnt == MAX_MS), m_ovf});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (obs !== RESET_OBS) begin
      miscompares++; $display("FAIL reset_state: got %b expected %b", obs, RESET_OBS);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    $display("reset: outputs %b", obs);
  endtask

  task automatic test_count_up();
    int ticks = 0;
    enable = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL count_up cyc%0d: got %b expected %b", i, obs, exp); end
      if (ms_tick === 1'b1) ticks++;
    end
    vectors++;
    if (timer_value !== 3'd3 || ticks != 3) begin
      miscompares++; $display("FAIL count_up_total: got value %0d ticks %0d expected value 3 ticks 3", timer_value, ticks);
    end
    $display("count_up: value %0d after %0d ticks", timer_value, ticks);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 24; i++) begin
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL overflow cyc%0d: got %b expected %b", i, obs, exp); end
    end
    vectors++;
    if (timer_value !== 3'd7 || at_max !== 1'b1 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL overflow_sat: got value %0d at_max %b ovf %b expected 7 1 1", timer_value, at_max, overflow);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL overflow_clear: got %b expected %b", obs, exp); end
    vectors++;
    if (timer_value !== 3'd0 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL clear_result: got value %0d ovf %b expected 0 0", timer_value, overflow);
    end
    $display("overflow: saturated at 7, cleared to %0d", timer_value);
  endtask

  task automatic test_count_down();
    load = 1'b1; load_value = 3'd3; up = 1'b0;
    cycle();
    load = 1'b0;
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL down_load: got %b expected %b", obs, exp); end
    for (int i = 1; i <= 16; i++) begin
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL down cyc%0d: got %b expected %b", i, obs, exp); end
    end
    vectors++;
    if (timer_value !== 3'd0 || at_zero !== 1'b1 || at_max !== 1'b0 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL down_floor: got value %0d at_zero %b at_max %b ovf %b expected 0 1 0 0", timer_value, at_zero, at_max, overflow);
    end
    $display("count_down: floor value %0d", timer_value);
  endtask

  task automatic test_clear_load();
    clear = 1'b1;
    cycle();
    clear = 1'b0; up = 1'b1;
    void'(sb.pop_front());
    for (int i = 1; i <= 3; i++) begin
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL clrld_pre cyc%0d: got %b expected %b", i, obs, exp); end
    end
    // Prescaler now sits at its last value: this edge would otherwise tick.
    clear = 1'b1; load = 1'b1; load_value = 3'd5;
    cycle();
    clear = 1'b0; load = 1'b0;
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL clear_load: got %b expected %b", obs, exp); end
    vectors++;
    if (timer_value !== 3'd0 || ms_tick !== 1'b0) begin
      miscompares++; $display("FAIL clear_wins: got value %0d tick %b expected 0 0", timer_value, ms_tick);
    end
    $display("clear_load: value %0d tick %b", timer_value, ms_tick);
  endtask

  task automatic test_enable_hold();
    int ticks = 0;
    load = 1'b1; load_value = 3'd2;
    cycle();
    load = 1'b0;
    void'(sb.pop_front());
    for (int i = 1; i <= 2; i++) begin
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL hold_pre cyc%0d: got %b expected %b", i, obs, exp); end
    end
    enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL hold cyc%0d: got %b expected %b", i, obs, exp); end
      if (ms_tick === 1'b1 || timer_value !== 3'd2) ticks++;
    end
    enable = 1'b1;
    cycle();
    void'(sb.pop_front());
    if (ms_tick === 1'b1) ticks++;
    cycle();
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hold_resume: got %b expected %b", obs, exp); end
    vectors++;
    if (ticks != 0 || ms_tick !== 1'b1 || timer_value !== 3'd3) begin
      miscompares++; $display("FAIL hold_latency: got early events %0d tick %b value %0d expected 0 1 3", ticks, ms_tick, timer_value);
    end
    $display("enable_hold: resumed tick, value %0d", timer_value);
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_value = 3'd4;
    cycle();
    load = 1'b0;
    void'(sb.pop_front());
    for (int i = 1; i <= 2; i++) begin
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL areset_pre cyc%0d: got %b expected %b", i, obs, exp); end
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== RESET_OBS) begin
      miscompares++; $display("FAIL async_reset: got %b expected %b", obs, RESET_OBS);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL areset_post cyc%0d: got %b expected %b", i, obs, exp); end
    end
    $display("async_reset: value after resume %0d", timer_value);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 80; i++) begin
      clear      = ($urandom_range(0, 15) == 0);
      load       = ($urandom_range(0, 11) == 0);
      enable     = ($urandom_range(0, 5) != 0);
      up         = ($urandom_range(0, 3) != 0);
      load_value = W'($urandom_range(0, 7));
      cycle();
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL random cyc%0d: got %b expected %b", i, obs, exp); end
    end
    clear = 1'b0; load = 1'b0;
    $display("back_to_back: final value %0d ovf %b", timer_value, overflow);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_overflow();
    test_count_down();
    test_clear_load();
    test_enable_hold();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
